// File: rtl/cpuregs_dbg.sv
// cpuregs_dbg: console examine / deposit / dump-all engine that borrows the
// register-file ports from a halted CPU through a request/grant handshake.
module cpuregs_dbg #(
  parameter int GNT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_addr,
  output logic [15:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        rf_req,
  input  logic        rf_gnt,
  output logic [5:0]  rf_raddr,
  input  logic [15:0] rf_o,
  output logic [5:0]  rf_waddr,
  output logic [15:0] rf_d,
  output logic        rf_we
);

  localparam int CNT_W = (GNT_TIMEOUT < 2) ? 1 : $clog2(GNT_TIMEOUT + 1);
  localparam logic [1:0] OP_EXAM = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [3:0] DUMP_LAST = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_GNT, S_RD_ADDR, S_RD_CAP, S_WR, S_RSP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [5:0]       addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [5:0]       rsp_addr_q, rsp_addr_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rf_req_q, rf_req_d;
  logic [5:0]       rf_raddr_q, rf_raddr_d;
  logic [5:0]       rf_waddr_q, rf_waddr_d;
  logic [15:0]      rf_d_q, rf_d_d;
  logic             rf_we_q, rf_we_d;
  logic [5:0]       cur_addr;

  // Logical address of dump entry idx: set-0 R0-R5, kernel SP,
  // set-1 R0-R5, supervisor SP, user SP.
  function automatic logic [5:0] dump_addr(input logic [3:0] idx);
    logic [5:0] a;
    if (idx <= 4'd5)       a = {3'b000, idx[2:0]};
    else if (idx == 4'd6)  a = 6'b000110;
    else if (idx <= 4'd12) a = {3'b001, 3'(idx - 4'd7)};
    else if (idx == 4'd13) a = 6'b010110;
    else                   a = 6'b110110;
    return a;
  endfunction

  // PC is not in the register file, and mode 10 has no stack pointer.
  function automatic logic cmd_is_bad(input logic [1:0] op, input logic [5:0] addr);
    logic rw;
    rw = (op == OP_EXAM) || (op == OP_DEP);
    return (op == 2'b11) ||
           (rw && (addr[2:0] == 3'd7)) ||
           (rw && (addr[2:0] == 3'd6) && (addr[5:4] == 2'b10));
  endfunction

  assign cur_addr = (op_q == OP_DUMP) ? dump_addr(idx_q) : addr_q;

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    rf_req_d    = rf_req_q;
    rf_raddr_d  = rf_raddr_q;
    rf_waddr_d  = rf_waddr_q;
    rf_d_d      = rf_d_q;
    rf_we_d     = rf_we_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          addr_d      = cmd_addr;
          data_d      = cmd_data;
          idx_d       = 4'd0;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          if (cmd_is_bad(cmd_op, cmd_addr)) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_data_d  = 16'h0000;
            rsp_addr_d  = cmd_addr;
          end else begin
            state_d  = S_WAIT_GNT;
            rf_req_d = 1'b1;
          end
        end
      end

      S_WAIT_GNT: begin
        if (rf_gnt) begin
          cnt_d = '0;
          if (op_q == OP_DEP) begin
            state_d    = S_WR;
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_q;
            rf_d_d     = data_q;
          end else begin
            state_d    = S_RD_ADDR;
            rf_raddr_d = cur_addr;
          end
        end else if (cnt_q == CNT_W'(GNT_TIMEOUT - 1)) begin
          state_d     = S_RSP;
          rf_req_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_data_d  = 16'h0000;
          rsp_addr_d  = cur_addr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RD_ADDR: begin
        if (!rf_gnt) begin
          state_d = S_WAIT_GNT;
          cnt_d   = '0;
        end else begin
          state_d = S_RD_CAP;
        end
      end

      S_RD_CAP: begin
        if (!rf_gnt) begin
          state_d = S_WAIT_GNT;
          cnt_d   = '0;
        end else begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rf_o;
          rsp_addr_d  = cur_addr;
          rsp_err_d   = 1'b0;
          rsp_last_d  = (op_q != OP_DUMP) || (idx_q == DUMP_LAST);
        end
      end

      S_WR: begin
        rf_we_d = 1'b0;
        if (!rf_gnt) begin
          state_d = S_WAIT_GNT;
          cnt_d   = '0;
        end else begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_q;
          rsp_addr_d  = addr_q;
          rsp_err_d   = 1'b0;
          rsp_last_d  = 1'b1;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if ((op_q == OP_DUMP) && !rsp_err_q && (idx_q != DUMP_LAST)) begin
            idx_d      = idx_q + 4'd1;
            state_d    = S_RD_ADDR;
            rf_raddr_d = dump_addr(idx_q + 4'd1);
          end else begin
            state_d     = S_IDLE;
            rf_req_d    = 1'b0;
            cmd_ready_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      addr_q      <= 6'd0;
      data_q      <= 16'h0000;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= 6'd0;
      rsp_data_q  <= 16'h0000;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rf_req_q    <= 1'b0;
      rf_raddr_q  <= 6'd0;
      rf_waddr_q  <= 6'd0;
      rf_d_q      <= 16'h0000;
      rf_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      rf_req_q    <= rf_req_d;
      rf_raddr_q  <= rf_raddr_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_d_q      <= rf_d_d;
      rf_we_q     <= rf_we_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign rf_req    = rf_req_q;
  assign rf_raddr  = rf_raddr_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_d      = rf_d_q;
  // A write that loses the grant mid-cycle must never reach the register file.
  assign rf_we     = rf_we_q & rf_gnt;

endmodule

// File: tb/tb_cpuregs_dbg.sv
// Testbench for cpuregs_dbg: table vectors, hand-written corner sequences and
// randomized commands checked against a command-level model.
`timescale 1ns/1ps
module tb_cpuregs_dbg;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_addr;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        rf_req;
  logic        rf_gnt;
  logic [5:0]  rf_raddr;
  logic [15:0] rf_o;
  logic [5:0]  rf_waddr;
  logic [15:0] rf_d;
  logic        rf_we;

  always #5 clk = ~clk;

  cpuregs_dbg #(.GNT_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_raddr(rf_raddr), .rf_o(rf_o),
    .rf_waddr(rf_waddr), .rf_d(rf_d), .rf_we(rf_we)
  );

  // Register-file stand-in plus free-running activity counters
  logic [15:0] mem [64];
  logic        mem_clr;
  logic [5:0]  last_waddr = 6'd0;
  logic [15:0] last_d = 16'h0;
  int          we_total = 0;
  int          we_viol = 0;
  int          req_total = 0;

  assign rf_o = mem[rf_raddr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    end else if (rf_we) begin
      mem[rf_waddr] <= rf_d;
      last_waddr    <= rf_waddr;
      last_d        <= rf_d;
    end
    if (rf_we) we_total <= we_total + 1;
    if (rf_we && !rf_gnt) we_viol <= we_viol + 1;
    if (rf_req) req_total <= req_total + 1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        err;
    logic [15:0] edata;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [64];
  rsp_t        got[$];
  rsp_t        exp_q[$];
  int          req_diff;
  logic [5:0]  dump_list [15] = '{6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06,
                                  6'o10, 6'o11, 6'o12, 6'o13, 6'o14, 6'o15, 6'o26, 6'o66};
  vec_t        vt [14];

  // stimulus modes: gnt 0=held high 1=held low 2=random short drops
  int gnt_mode = 0, low_run = 0, drop_at = 0, drop_len = 0;
  int rdy_mode = 0, rdy_hold = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  function automatic bit bad_cmd(input logic [1:0] op, input logic [5:0] a);
    if (op == 2'd3) return 1'b1;
    if (op == 2'd2) return 1'b0;
    if (a[2:0] == 3'd7) return 1'b1;
    return (a[2:0] == 3'd6) && (a[5:4] == 2'd2);
  endfunction

  // Advance to the next falling edge and choose grant/ready for the next cycle.
  task automatic tick();
    logic g, b, r;
    @(negedge clk);
    if (gnt_mode == 0) b = 1'b1;
    else if (gnt_mode == 1) b = 1'b0;
    else if (low_run >= 3) b = 1'b1;
    else b = ($urandom_range(3) != 0);
    if (drop_at > 0) begin
      drop_at--;
      g = b;
    end else if (drop_len > 0) begin
      drop_len--;
      g = 1'b0;
    end else begin
      g = b;
    end
    if (gnt_mode == 2) low_run = b ? 0 : low_run + 1;
    if (rsp_valid && rdy_hold > 0) begin
      rdy_hold--;
      r = 1'b0;
    end else if (rdy_mode == 0) r = 1'b1;
    else r = 1'($urandom_range(1));
    rf_gnt    = g;
    rsp_ready = r;
  endtask

  // Issue one command, collect every response and compare with the model.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] a,
                        input logic [15:0] d, input bit tmo);
    int   n, we0, viol0, req0;
    bit   isbad, done, pend;
    rsp_t cur, prev;
    got.delete();
    exp_q.delete();
    isbad = bad_cmd(op, a);
    prev  = '0;
    if (isbad || tmo) exp_q.push_back('{addr: a, data: 16'h0, last: 1'b1, err: 1'b1});
    else if (op == 2'd2)
      for (int i = 0; i < 15; i++)
        exp_q.push_back('{addr: dump_list[i], data: model[dump_list[i]], last: (i == 14), err: 1'b0});
    else if (op == 2'd1) exp_q.push_back('{addr: a, data: d, last: 1'b1, err: 1'b0});
    else exp_q.push_back('{addr: a, data: model[a], last: 1'b1, err: 1'b0});

    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) begin
      check("cmd_ready_wait", 0, 1);
      return;
    end
    we0 = we_total; viol0 = we_viol; req0 = req_total;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", int'(cmd_ready), 0);

    n = 0; done = 0; pend = 0;
    while (!done && n < 3000 && got.size() < 16) begin
      if (pend && !rsp_valid) check("rsp_dropped", 0, 1);
      if (rsp_valid) begin
        cur = '{addr: rsp_addr, data: rsp_data, last: rsp_last, err: rsp_err};
        if (pend) check("rsp_stable", int'(cur), int'(prev));
        if (rsp_ready) begin
          got.push_back(cur);
          pend = 0;
          if (rsp_last) done = 1;
        end else begin
          pend = 1;
          prev = cur;
        end
      end else begin
        pend = 0;
      end
      tick();
      n++;
    end
    if (!done) check("rsp_last_wait", 0, 1);
    check("idle_ready", int'(cmd_ready), 1);
    check("idle_req", int'(rf_req), 0);

    check("rsp_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (exp_q[i].err)
        check($sformatf("rsp_err_%0d", i), int'({got[i].data, got[i].last, got[i].err}),
              int'({exp_q[i].data, exp_q[i].last, exp_q[i].err}));
      else
        check($sformatf("rsp_%0d", i), int'(got[i]), int'(exp_q[i]));
    end

    req_diff = req_total - req0;
    check("we_pulses", we_total - we0, (op == 2'd1 && !isbad && !tmo) ? 1 : 0);
    check("we_without_gnt", we_viol - viol0, 0);
    if (isbad) check("req_on_bad_cmd", req_diff, 0);
    if (op == 2'd1 && !isbad && !tmo) begin
      check("wr_addr", int'(last_waddr), int'(a));
      check("wr_data", int'(last_d), int'(d));
      model[a] = d;
    end
  endtask

  initial begin
    int nlast;
    vt[0]  = '{2'd1, 6'o03, 16'h1234, 1'b0, 16'h1234};
    vt[1]  = '{2'd0, 6'o03, 16'h0000, 1'b0, 16'h1234};
    vt[2]  = '{2'd0, 6'o07, 16'h0000, 1'b1, 16'h0000};
    vt[3]  = '{2'd3, 6'o01, 16'hFFFF, 1'b1, 16'h0000};
    vt[4]  = '{2'd1, 6'o46, 16'h4444, 1'b1, 16'h0000};
    vt[5]  = '{2'd0, 6'o57, 16'h0000, 1'b1, 16'h0000};
    vt[6]  = '{2'd1, 6'o12, 16'hBEEF, 1'b0, 16'hBEEF};
    vt[7]  = '{2'd0, 6'o12, 16'h0000, 1'b0, 16'hBEEF};
    vt[8]  = '{2'd1, 6'o06, 16'h1000, 1'b0, 16'h1000};
    vt[9]  = '{2'd1, 6'o26, 16'h2000, 1'b0, 16'h2000};
    vt[10] = '{2'd1, 6'o66, 16'h3000, 1'b0, 16'h3000};
    vt[11] = '{2'd0, 6'o26, 16'h0000, 1'b0, 16'h2000};
    vt[12] = '{2'd1, 6'o45, 16'h5555, 1'b0, 16'h5555};
    vt[13] = '{2'd0, 6'o45, 16'h0000, 1'b0, 16'h5555};
    for (int i = 0; i < 64; i++) model[i] = 16'h0;

    reset = 1'b1; mem_clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_addr = 6'd0; cmd_data = 16'h0; rsp_ready = 1'b1; rf_gnt = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_ctl", int'({rsp_valid, rsp_last, rsp_err, rf_req, rf_we}), 0);
    check("rst_rsp", int'({rsp_addr, rsp_data}), 0);
    check("rst_rf", int'({rf_raddr, rf_waddr, rf_d}), 0);
    reset = 1'b0; mem_clr = 1'b0;
    tick();

    // table-driven examine/deposit/error vectors
    for (int i = 0; i < 14; i++) begin
      do_cmd(vt[i].op, vt[i].addr, vt[i].data, 1'b0);
      if (got.size() > 0) begin
        check($sformatf("vec%0d_err", i), int'(got[0].err), int'(vt[i].err));
        check($sformatf("vec%0d_data", i), int'(got[0].data), int'(vt[i].edata));
        check($sformatf("vec%0d_last", i), int'(got[0].last), 1);
      end else begin
        check($sformatf("vec%0d_none", i), 0, 1);
      end
    end

    // full dump with the preloaded registers
    do_cmd(2'd2, 6'o00, 16'h0, 1'b0);
    if (got.size() == 15) begin
      check("dump10", int'({got[9].addr, got[9].data}), int'({6'o12, 16'hBEEF}));
      check("dump7", int'({got[6].addr, got[6].data}), int'({6'o06, 16'h1000}));
      check("dump14", int'({got[13].addr, got[13].data}), int'({6'o26, 16'h2000}));
      check("dump15", int'({got[14].addr, got[14].data, got[14].last}), int'({6'o66, 16'h3000, 1'b1}));
      nlast = 0;
      for (int i = 0; i < 14; i++) nlast += int'(got[i].last);
      check("dump_early_last", nlast, 0);
    end else begin
      check("dump_size", got.size(), 15);
    end

    // dumps with backpressure and a grant drop at various read phases
    for (int k = 0; k < 4; k++) begin
      drop_at = 5 + k; drop_len = 3; rdy_hold = 5;
      do_cmd(2'd2, 6'o00, 16'h0, 1'b0);
    end

    // grant never arrives
    gnt_mode = 1;
    do_cmd(2'd0, 6'o03, 16'h0, 1'b1);
    check("tmo_req_cycles", req_diff, TMO);
    gnt_mode = 0;
    tick();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      int sel;
      logic [1:0] op;
      sel = $urandom_range(9);
      op = (sel < 3) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      gnt_mode = ($urandom_range(1) == 0) ? 0 : 2;
      rdy_mode = $urandom_range(1);
      low_run = 0;
      do_cmd(op, 6'($urandom_range(63)), 16'($urandom_range(65535)), 1'b0);
    end
    gnt_mode = 0; rdy_mode = 0;
    tick();

    // reset during the write cycle
    begin
      int n, we0;
      cmd_op = 2'd1; cmd_addr = 6'o04; cmd_data = 16'hAAAA; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (!rf_we && n < 10) begin tick(); n++; end
      check("reach_wr", int'(rf_we), 1);
      reset = 1'b1;
      tick();
      check("rstwr_ready", int'(cmd_ready), 1);
      check("rstwr_ctl", int'({rf_req, rf_we, rsp_valid}), 0);
      reset = 1'b0;
      we0 = we_total;
      repeat (5) tick();
      check("rstwr_no_write", we_total - we0, 0);
      model[6'o04] = 16'hAAAA;
    end

    // reset while waiting for grant
    gnt_mode = 1;
    cmd_op = 2'd0; cmd_addr = 6'o02; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("wait_req", int'(rf_req), 1);
    reset = 1'b1;
    tick();
    check("rstwait_ready", int'(cmd_ready), 1);
    check("rstwait_ctl", int'({rf_req, rf_we, rsp_valid}), 0);
    reset = 1'b0;
    gnt_mode = 0;
    tick();

    do_cmd(2'd1, 6'o05, 16'h7777, 1'b0);
    do_cmd(2'd0, 6'o05, 16'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
